hms_clock: RTL and testbench
============================

HMS_CLOCK -- requirements
Module: hms_clock

Interface
REQ-001 SHALL have parameter HOUR_MOD, default 24, hour count modulus; legal range 2..24.
REQ-002 SHALL have port clk, input, 1, system clock; all logic in this block is clocked on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port tick, input, 1, one-clk-wide 1 Hz enable pulse, synchronous to clk.
REQ-005 SHALL have port btn_mode, input, 1, one-clk-wide pulse, already debounced; advances the mode.
REQ-006 SHALL have port btn_inc, input, 1, one-clk-wide pulse, already debounced; increments the selected field.
REQ-007 SHALL have port alarm_hh, input, 5, alarm hour in binary.
REQ-008 SHALL have port alarm_mm, input, 6, alarm minute in binary.
REQ-009 SHALL have port sec, output, 6, seconds in binary, 0..59.
REQ-010 SHALL have port min, output, 6, minutes in binary, 0..59.
REQ-011 SHALL have port hour, output, 5, hours in binary, 0..HOUR_MOD-1.
REQ-012 SHALL have ports sec_bcd, min_bcd and hour_bcd, output, 8 each, packed BCD {tens, ones}.
REQ-013 SHALL have port mode, output, 2, current FSM state encoding.
REQ-014 SHALL have port day_pulse, output, 1, one-clk pulse on wrap from (HOUR_MOD-1):59:59 to 00:00:00.
REQ-015 SHALL have port alarm, output, 1, alarm match flag.

Function
REQ-016 SHALL implement FSM states RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3.
REQ-017 SHALL advance the state on btn_mode as RUN->SET_HOUR->SET_MIN->SET_SEC->RUN; the new state is visible on mode the next cycle.
REQ-018 SHALL, in RUN, increment sec on tick, registered; the new value appears the cycle after tick.
REQ-019 SHALL, in RUN, on a tick with sec=59, set sec to 0 and increment min in the same cycle.
REQ-020 SHALL, in RUN, on a tick with sec=59 and min=59, set min to 0 and increment hour.
REQ-021 SHALL, in RUN, on a tick at (HOUR_MOD-1):59:59, set all fields to 0 and assert day_pulse for exactly one cycle.
REQ-022 SHALL ignore tick in any SET_* state; ticks are dropped, not queued.
REQ-023 SHALL, in a SET_* state, make btn_inc increment only the selected field modulo its range; no carry into other fields and no day_pulse.
REQ-024 SHALL ignore btn_inc in RUN.
REQ-025 SHALL resolve simultaneous events using the state current in that cycle: tick+btn_mode in RUN applies the tick and changes state; btn_inc+btn_mode in SET_x increments field x and changes state.
REQ-026 SHALL derive the BCD outputs combinationally from the registered binary fields, with zero extra latency.
REQ-027 SHALL use unsigned arithmetic for all fields; values outside the legal ranges are unreachable.

Reset
REQ-028 SHALL, while rst_n=0, drive sec, min, hour to 0, all BCD outputs to 8'h00, mode to RUN, and day_pulse and alarm to 0.
REQ-029 SHALL, on reset asserted mid-operation, including in a SET_* state, clear immediately and drop any pending event.

Configuration
REQ-030 SHALL, with macro HMS_ALARM_EN defined, drive alarm as a registered output: high the cycle after mode=RUN and hour=alarm_hh and min=alarm_mm, low otherwise.
REQ-031 SHALL, without HMS_ALARM_EN, hold alarm at constant 0, keep alarm_hh and alarm_mm as ports, and ignore them.

Structure
REQ-032 SHALL place the mode enum (RUN, SET_HOUR, SET_MIN, SET_SEC), SEC_MOD=60 and MIN_MOD=60 in shared package hms_pkg.
REQ-033 SHALL implement each field with sub-module mod_counter (parameter MOD; ports inc, clr, value, wrap), instantiated three times; the binary-to-BCD conversion is a package function in hms_pkg.

Verification
REQ-034 SHALL cover reset followed by 61 ticks in RUN -> 00:01:01, sec_bcd=8'h01, min_bcd=8'h01.
REQ-035 SHALL cover preloading 23:59:59 with HOUR_MOD=24 and applying a tick -> 00:00:00, day_pulse high for 1 cycle.
REQ-036 SHALL cover btn_mode once then 5 btn_inc pulses from 00:00:00 -> hour=5, min=0, sec=0, mode=1; 10 ticks applied meanwhile have no effect.
REQ-037 SHALL cover SET_MIN at min=59 with btn_inc -> min=0, hour unchanged, no day_pulse.
REQ-038 SHALL cover tick and btn_mode in the same cycle at 00:00:10 in RUN -> sec=11 and mode=SET_HOUR the next cycle.
REQ-039 SHALL cover alarm_hh=1, alarm_mm=2 with HMS_ALARM_EN defined -> alarm rises the cycle after 01:02:00 and falls after 01:03:00; without the macro alarm stays 0.

Source files
------------

// File: rtl/hms_pkg.sv
// Shared types, field moduli and the binary-to-BCD helper for the hms_clock block.
package hms_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_e;

  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;

  // Packed {tens, ones}; inputs never exceed 59, so tens fits in one nibble.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 7'd10);
    ones = 4'(v % 7'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with synchronous clear; wrap flags the increment that rolls over to 0.
module mod_counter #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         wrap
);

  logic at_max;

  assign at_max = (value == W'(MOD - 1));
  assign wrap   = inc & at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= at_max ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/hms_clock.sv
// Hours/minutes/seconds clock with RUN/SET_* mode FSM and BCD outputs.
// Optional registered alarm compare is built when HMS_ALARM_EN is defined.
module hms_clock
  import hms_pkg::*;
#(
  parameter int HOUR_MOD = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] alarm_hh,
  input  logic [5:0] alarm_mm,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic [1:0] mode,
  output logic       day_pulse,
  output logic       alarm
);

  // tick, btn_mode and btn_inc are single-cycle strobes sampled on the rising
  // edge of clk; there is no backpressure, an event not acted on is dropped.

  mode_e state_q;
  mode_e state_d;

  logic run_en;
  logic set_hour_sel;
  logic set_min_sel;
  logic set_sec_sel;

  logic sec_inc;
  logic min_inc;
  logic hour_inc;
  logic sec_wrap;
  logic min_wrap;
  logic hour_wrap;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (btn_mode) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        SET_SEC:  state_d = RUN;
        default:  state_d = RUN;
      endcase
    end
  end

  // Output decode
  always_comb begin
    run_en       = 1'b0;
    set_hour_sel = 1'b0;
    set_min_sel  = 1'b0;
    set_sec_sel  = 1'b0;
    case (state_q)
      RUN:      run_en       = 1'b1;
      SET_HOUR: set_hour_sel = 1'b1;
      SET_MIN:  set_min_sel  = 1'b1;
      SET_SEC:  set_sec_sel  = 1'b1;
      default:  run_en       = 1'b0;
    endcase
  end

  // Carries ripple only while running; in SET_* a field wraps on its own.
  assign sec_inc  = run_en ? tick     : (set_sec_sel  & btn_inc);
  assign min_inc  = run_en ? sec_wrap : (set_min_sel  & btn_inc);
  assign hour_inc = run_en ? min_wrap : (set_hour_sel & btn_inc);

  mod_counter #(.MOD(SEC_MOD), .W(6)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_inc),
    .clr   (1'b0),
    .value (sec),
    .wrap  (sec_wrap)
  );

  mod_counter #(.MOD(MIN_MOD), .W(6)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .clr   (1'b0),
    .value (min),
    .wrap  (min_wrap)
  );

  mod_counter #(.MOD(HOUR_MOD), .W(5)) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hour_inc),
    .clr   (1'b0),
    .value (hour),
    .wrap  (hour_wrap)
  );

  // Only a running-mode carry out of the hour field marks a new day.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_pulse <= 1'b0;
    end else begin
      day_pulse <= run_en & hour_wrap;
    end
  end

  assign sec_bcd  = to_bcd({1'b0, sec});
  assign min_bcd  = to_bcd({1'b0, min});
  assign hour_bcd = to_bcd({2'b00, hour});
  assign mode     = state_q;

`ifdef HMS_ALARM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= 1'b0;
    end else begin
      alarm <= run_en && (hour == alarm_hh) && (min == alarm_mm);
    end
  end
`else
  logic unused_alarm_in;
  assign unused_alarm_in = ^{alarm_hh, alarm_mm};
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_hms_clock.sv
// Randomized scoreboard bench for hms_clock against a seconds-of-day reference model.
module tb_hms_clock;

  localparam int HM = 24;
  localparam int VW = 45;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] alarm_hh;
  logic [5:0] alarm_mm;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hour_bcd;
  logic [1:0] mode;
  logic       day_pulse;
  logic       alarm;

  hms_clock #(.HOUR_MOD(HM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .alarm_hh  (alarm_hh),
    .alarm_mm  (alarm_mm),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .sec_bcd   (sec_bcd),
    .min_bcd   (min_bcd),
    .hour_bcd  (hour_bcd),
    .mode      (mode),
    .day_pulse (day_pulse),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model state: time of day, mode index, and the two flags
  int m_h, m_m, m_s, m_mode, m_day, m_alarm;
  int ah_set = 31;
  int am_set = 63;
  string phase = "init";

  logic [VW-1:0] exp_q[$];
  string         tag_q[$];

  logic [VW-1:0] dut_vec;
  assign dut_vec = {hour, min, sec, mode, day_pulse, alarm, hour_bcd, min_bcd, sec_bcd};

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function logic [VW-1:0] model_vec();
    return {5'(m_h), 6'(m_m), 6'(m_s), 2'(m_mode), 1'(m_day), 1'(m_alarm),
            bcd(m_h), bcd(m_m), bcd(m_s)};
  endfunction

  function automatic string vstr(input logic [VW-1:0] v);
    return $sformatf("%0d:%0d:%0d mode=%0d day=%0b alarm=%0b bcd=%h:%h:%h",
                     v[44:40], v[39:34], v[33:28], v[27:26], v[25], v[24],
                     v[23:16], v[15:8], v[7:0]);
  endfunction

  task automatic model_clear();
    m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_day = 0; m_alarm = 0;
  endtask

  // One clock of the reference: time kept as seconds-of-day while running.
  task automatic model_update(input bit t, input bit bm, input bit bi);
    int total;
`ifdef HMS_ALARM_EN
    m_alarm = (m_mode == 0 && m_h == ah_set && m_m == am_set) ? 1 : 0;
`else
    m_alarm = 0;
`endif
    m_day = 0;
    case (m_mode)
      0: if (t) begin
        total = m_h * 3600 + m_m * 60 + m_s + 1;
        if (total == HM * 3600) begin
          total = 0;
          m_day = 1;
        end
        m_h = total / 3600;
        m_m = (total / 60) % 60;
        m_s = total % 60;
      end
      1: if (bi) m_h = (m_h + 1) % HM;
      2: if (bi) m_m = (m_m + 1) % 60;
      default: if (bi) m_s = (m_s + 1) % 60;
    endcase
    if (bm) m_mode = (m_mode + 1) % 4;
  endtask

  task automatic step(input bit t, input bit bm, input bit bi);
    @(negedge clk);
    alarm_hh = 5'(ah_set);
    alarm_mm = 6'(am_set);
    tick = t;
    btn_mode = bm;
    btn_inc = bi;
    model_update(t, bm, bi);
    exp_q.push_back(model_vec());
    tag_q.push_back(phase);
  endtask

  task automatic check_vec(input string name, input logic [VW-1:0] exp);
    checks++;
    if (dut_vec === exp) passes++;
    else $display("FAIL %s: got %s expected %s", name, vstr(dut_vec), vstr(exp));
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    alarm_hh = 5'(ah_set);
    alarm_mm = 6'(am_set);
    rst_n = 1'b0;
    tick = 1'b0;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    model_clear();
    #1;
    check_vec({phase, "_reset_async"}, model_vec());
    repeat (2) begin
      @(negedge clk);
      exp_q.push_back(model_vec());
      tag_q.push_back({phase, "_in_reset"});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_update(1'b0, 1'b0, 1'b0);
    exp_q.push_back(model_vec());
    tag_q.push_back({phase, "_release"});
  endtask

  task automatic preload(input int h, input int m, input int s);
    step(0, 1, 0);
    repeat (h) step(0, 0, 1);
    step(0, 1, 0);
    repeat (m) step(0, 0, 1);
    step(0, 1, 0);
    repeat (s) step(0, 0, 1);
    step(0, 1, 0);
  endtask

  // Monitor: every clock with a pending expectation is compared
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [VW-1:0] e;
        string tg;
        e = exp_q.pop_front();
        tg = tag_q.pop_front();
        check_vec(tg, e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    checks++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    tick = 1'b0;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    alarm_hh = 5'(ah_set);
    alarm_mm = 6'(am_set);
    model_clear();

    phase = "por";
    do_reset();
    check_int("por_sec_bcd", int'(sec_bcd), 0);

    phase = "ticks61";
    for (int i = 0; i < 61; i++) begin
      step(1, 0, 0);
      if ($urandom_range(0, 1) == 1) step(0, 0, 0);
    end
    settle();
    check_int("t61_hour", int'(hour), 0);
    check_int("t61_min", int'(min), 1);
    check_int("t61_sec", int'(sec), 1);
    check_int("t61_sec_bcd", int'(sec_bcd), 8'h01);
    check_int("t61_min_bcd", int'(min_bcd), 8'h01);

    phase = "set_hour";
    do_reset();
    step(0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 0, i < 5);
    settle();
    check_int("seth_hour", int'(hour), 5);
    check_int("seth_min", int'(min), 0);
    check_int("seth_sec", int'(sec), 0);
    check_int("seth_mode", int'(mode), 1);

    phase = "set_min_wrap";
    step(0, 1, 0);
    repeat (59) step(0, 0, 1);
    settle();
    check_int("setm_min59", int'(min), 59);
    step(0, 0, 1);
    settle();
    check_int("setm_min0", int'(min), 0);
    check_int("setm_hour", int'(hour), 5);
    check_int("setm_day", int'(day_pulse), 0);

    phase = "mid_set_reset";
    step(0, 1, 0);
    step(0, 0, 1);
    do_reset();

    phase = "day_wrap";
    preload(23, 59, 59);
    step(1, 0, 0);
    settle();
    check_int("day_hms", int'({hour, min, sec}), 0);
    check_int("day_pulse_hi", int'(day_pulse), 1);
    step(0, 0, 0);
    settle();
    check_int("day_pulse_lo", int'(day_pulse), 0);

    phase = "tick_mode";
    do_reset();
    repeat (10) step(1, 0, 0);
    step(1, 1, 0);
    settle();
    check_int("tm_sec", int'(sec), 11);
    check_int("tm_mode", int'(mode), 1);

    phase = "alarm";
    ah_set = 1;
    am_set = 2;
    do_reset();
    preload(1, 1, 59);
    step(1, 0, 0);
    step(0, 0, 0);
    settle();
`ifdef HMS_ALARM_EN
    check_int("alarm_rise", int'(alarm), 1);
`else
    check_int("alarm_off", int'(alarm), 0);
`endif
    repeat (59) step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    settle();
    check_int("alarm_fall", int'(alarm), 0);

    phase = "random";
    ah_set = 31;
    am_set = 63;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 149) == 0) begin
          if ($urandom_range(0, 1) == 1) begin
            ah_set = m_h;
            am_set = (m_m + 1) % 60;
          end else begin
            ah_set = $urandom_range(0, HM - 1);
            am_set = $urandom_range(0, 59);
          end
        end
        step($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 2) == 0);
      end
    end

    phase = "drain";
    step(0, 0, 0);
    settle();
    check_int("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
